tour_cmd: RTL and testbench

TOUR_CMD -- requirements
Module: tour_cmd

---
 rtl/tour_cmd_if.sv | 25 ++
 rtl/tour_cmd.sv | 131 +++++++++++++
 tb/tb_tour_cmd.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tour_cmd_if.sv
// Handshake bundle between the tour sequencer, the UART/BLE wrapper,
// the command processor and the solver move store.
interface tour_cmd_if;
  logic        tour_go;
  logic [4:0]  mv_indx;
  logic [7:0]  move;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;

  modport master (
    input  tour_go, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
  );

  modport slave (
    output tour_go, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
  );
endinterface

// File: rtl/tour_cmd.sv
// Tour sequencer: replays solver knight moves as two-leg commands to the
// command processor, otherwise passing UART commands straight through.
module tour_cmd #(
  parameter int NUM_MOVES = 24
) (
  input logic        clk,
  input logic        rst,
  tour_cmd_if.master bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] LEG1  = 3'd2;
  localparam logic [2:0] WAIT1 = 3'd3;
  localparam logic [2:0] LEG2  = 3'd4;
  localparam logic [2:0] WAIT2 = 3'd5;

  localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_FANFARE = 4'h3;
  localparam logic [7:0] HEAD_N     = 8'h00;
  localparam logic [7:0] HEAD_W     = 8'h3F;
  localparam logic [7:0] HEAD_S     = 8'h7F;
  localparam logic [7:0] HEAD_E     = 8'hBF;

  localparam logic [7:0] RESP_IDLE = 8'hA5;
  localparam logic [7:0] RESP_TOUR = 8'h5A;
  localparam logic [7:0] RESP_ERR  = 8'hEE;

  logic [2:0]  state;
  logic [2:0]  nxt_state;
  logic [4:0]  mv_indx_q;
  logic [7:0]  mv_reg;
  logic        err;
  logic [7:0]  vert_head;
  logic [2:0]  vert_sq;
  logic [7:0]  horz_head;
  logic [2:0]  horz_sq;
  logic [15:0] cmd_leg1;
  logic [15:0] cmd_leg2;
  logic        pass_thru;

  function automatic logic is_one_hot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  // Split the registered knight move into its vertical and horizontal legs
  always_comb begin
    vert_head = HEAD_N;
    vert_sq   = 3'd0;
    horz_head = HEAD_W;
    horz_sq   = 3'd0;
    case (mv_reg)
      8'h01: begin vert_head = HEAD_N; vert_sq = 3'd2; horz_head = HEAD_W; horz_sq = 3'd1; end
      8'h02: begin vert_head = HEAD_N; vert_sq = 3'd2; horz_head = HEAD_E; horz_sq = 3'd1; end
      8'h04: begin vert_head = HEAD_N; vert_sq = 3'd1; horz_head = HEAD_W; horz_sq = 3'd2; end
      8'h08: begin vert_head = HEAD_S; vert_sq = 3'd1; horz_head = HEAD_W; horz_sq = 3'd2; end
      8'h10: begin vert_head = HEAD_S; vert_sq = 3'd2; horz_head = HEAD_W; horz_sq = 3'd1; end
      8'h20: begin vert_head = HEAD_S; vert_sq = 3'd2; horz_head = HEAD_E; horz_sq = 3'd1; end
      8'h40: begin vert_head = HEAD_S; vert_sq = 3'd1; horz_head = HEAD_E; horz_sq = 3'd2; end
      8'h80: begin vert_head = HEAD_N; vert_sq = 3'd1; horz_head = HEAD_E; horz_sq = 3'd2; end
      default: ;
    endcase
  end

  assign cmd_leg1 = {OP_MOVE, vert_head, 1'b0, vert_sq};
  assign cmd_leg2 = {OP_FANFARE, horz_head, 1'b0, horz_sq};

  // send_resp is only honoured in the WAIT states, so an early pulse that
  // lands with clr_cmd_rdy cannot skip a leg
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:  if (bus.tour_go) nxt_state = LOAD;
      LOAD:  nxt_state = is_one_hot(bus.move) ? LEG1 : IDLE;
      LEG1:  if (bus.clr_cmd_rdy) nxt_state = WAIT1;
      WAIT1: if (bus.send_resp) nxt_state = LEG2;
      LEG2:  if (bus.clr_cmd_rdy) nxt_state = WAIT2;
      WAIT2: if (bus.send_resp) nxt_state = (mv_indx_q == LAST_INDX) ? IDLE : LOAD;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mv_indx_q <= 5'd0;
      mv_reg    <= 8'd0;
      err       <= 1'b0;
    end else begin
      state <= nxt_state;
      case (state)
        IDLE: begin
          if (bus.tour_go) begin
            mv_indx_q <= 5'd0;
            err       <= 1'b0;
          end
        end
        LOAD: begin
          mv_reg <= bus.move;
          if (!is_one_hot(bus.move)) err <= 1'b1;
        end
        WAIT2: begin
          if (bus.send_resp && (mv_indx_q != LAST_INDX)) mv_indx_q <= mv_indx_q + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Reset forces passthrough combinationally so the UART path is live
  // even before the synchronous reset has taken effect
  assign pass_thru = rst || (state == IDLE);

  always_comb begin
    bus.cmd              = bus.cmd_UART;
    bus.cmd_rdy          = bus.cmd_rdy_UART;
    bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
    bus.resp             = (err && !rst) ? RESP_ERR : RESP_IDLE;
    if (!pass_thru) begin
      bus.cmd              = ((state == LEG2) || (state == WAIT2)) ? cmd_leg2 : cmd_leg1;
      bus.cmd_rdy          = (state == LEG1) || (state == LEG2);
      bus.clr_cmd_rdy_UART = 1'b0;
      bus.resp             = RESP_TOUR;
    end
  end

  assign bus.mv_indx = mv_indx_q;

endmodule

// File: tb/tb_tour_cmd.sv
// Self-checking bench for tour_cmd: a 24-move and a 1-move instance, with
// expected commands queued as moves are loaded and popped as cmd_rdy rises.
module tb_tour_cmd;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp;
  logic [7:0]  store24[32];
  logic [7:0]  store1[32];

  always #5 clk = ~clk;

  tour_cmd_if b24();
  tour_cmd_if b1();

  assign b24.move = store24[b24.mv_indx];
  assign b1.move  = store1[b1.mv_indx];

  tour_cmd #(.NUM_MOVES(24)) dut24 (.clk(clk), .rst(rst), .bus(b24.master));
  tour_cmd #(.NUM_MOVES(1))  dut1  (.clk(clk), .rst(rst), .bus(b1.master));

  // Independent reference: legal one-hot move to its two expected commands
  function automatic logic [15:0] exp_leg1(input logic [7:0] mv);
    case (mv)
      8'h01, 8'h02: return 16'h2002;
      8'h04, 8'h80: return 16'h2001;
      8'h08, 8'h40: return 16'h27F1;
      8'h10, 8'h20: return 16'h27F2;
      default:      return 16'hFFFF;
    endcase
  endfunction

  function automatic logic [15:0] exp_leg2(input logic [7:0] mv);
    case (mv)
      8'h01, 8'h10: return 16'h33F1;
      8'h02, 8'h20: return 16'h3BF1;
      8'h04, 8'h08: return 16'h33F2;
      8'h40, 8'h80: return 16'h3BF2;
      default:      return 16'hFFFF;
    endcase
  endfunction

  task automatic push_move(input logic [7:0] mv);
    exp_q.push_back(exp_leg1(mv));
    exp_q.push_back(exp_leg2(mv));
  endtask

  task automatic wait_rdy24(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (b24.cmd_rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic start_tour24();
    b24.tour_go = 1'b1;
    @(negedge clk);
    b24.tour_go = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b24.cmd_UART = 16'hC3C3;
    b24.cmd_rdy_UART = 1'b1;
    #1;
    checks++;
    if (b24.cmd_rdy !== 1'b1) begin fails++; $display("[TB] FAIL reset_cmd_rdy: got %b expected 1", b24.cmd_rdy); end
    checks++;
    if (b24.resp !== 8'hA5) begin fails++; $display("[TB] FAIL reset_resp: got %h expected a5", b24.resp); end
    @(negedge clk);
    checks++;
    if (b24.mv_indx !== 5'd0) begin fails++; $display("[TB] FAIL reset_mv_indx: got %0d expected 0", b24.mv_indx); end
    checks++;
    if (b24.cmd !== 16'hC3C3) begin fails++; $display("[TB] FAIL reset_cmd: got %h expected c3c3", b24.cmd); end
    checks++;
    if (b1.resp !== 8'hA5) begin fails++; $display("[TB] FAIL reset_resp1: got %h expected a5", b1.resp); end
    rst = 1'b0;
    b24.cmd_rdy_UART = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    b24.cmd_UART = 16'h0000;
    b24.cmd_rdy_UART = 1'b1;
    b24.clr_cmd_rdy = 1'b1;
    #1;
    checks++;
    if (b24.cmd !== 16'h0000) begin fails++; $display("[TB] FAIL pass_cmd: got %h expected 0000", b24.cmd); end
    checks++;
    if (b24.cmd_rdy !== 1'b1) begin fails++; $display("[TB] FAIL pass_cmd_rdy: got %b expected 1", b24.cmd_rdy); end
    checks++;
    if (b24.clr_cmd_rdy_UART !== 1'b1) begin fails++; $display("[TB] FAIL pass_clr: got %b expected 1", b24.clr_cmd_rdy_UART); end
    checks++;
    if (b24.resp !== 8'hA5) begin fails++; $display("[TB] FAIL pass_resp: got %h expected a5", b24.resp); end
    @(negedge clk);
    b24.cmd_UART = 16'h5A3C;
    b24.cmd_rdy_UART = 1'b0;
    b24.clr_cmd_rdy = 1'b0;
    #1;
    checks++;
    if (b24.cmd !== 16'h5A3C) begin fails++; $display("[TB] FAIL pass_cmd2: got %h expected 5a3c", b24.cmd); end
    checks++;
    if (b24.cmd_rdy !== 1'b0 || b24.clr_cmd_rdy_UART !== 1'b0) begin
      fails++; $display("[TB] FAIL pass_ctrl2: got rdy=%b clr=%b expected 0/0", b24.cmd_rdy, b24.clr_cmd_rdy_UART);
    end
    @(negedge clk);
  endtask

  task automatic test_single_move();
    store1[0] = 8'h01;
    exp_q.delete();
    push_move(8'h01);
    b1.tour_go = 1'b1;
    @(negedge clk);
    b1.tour_go = 1'b0;
    checks++;
    if (b1.cmd_rdy !== 1'b0 || b1.resp !== 8'h5A) begin
      fails++; $display("[TB] FAIL single_load: got rdy=%b resp=%h expected 0/5a", b1.cmd_rdy, b1.resp);
    end
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (b1.cmd_rdy !== 1'b1) begin fails++; $display("[TB] FAIL single_latency: got cmd_rdy %b expected 1", b1.cmd_rdy); end
    checks++;
    if (b1.cmd !== exp) begin fails++; $display("[TB] FAIL single_leg1: got %h expected %h", b1.cmd, exp); end
    b1.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    b1.clr_cmd_rdy = 1'b0;
    checks++;
    if (b1.cmd_rdy !== 1'b0 || b1.cmd !== exp) begin
      fails++; $display("[TB] FAIL single_wait1: got rdy=%b cmd=%h expected 0/%h", b1.cmd_rdy, b1.cmd, exp);
    end
    b1.send_resp = 1'b1;
    @(negedge clk);
    b1.send_resp = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (b1.cmd_rdy !== 1'b1 || b1.cmd !== exp) begin
      fails++; $display("[TB] FAIL single_leg2: got rdy=%b cmd=%h expected 1/%h", b1.cmd_rdy, b1.cmd, exp);
    end
    b1.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    b1.clr_cmd_rdy = 1'b0;
    b1.send_resp = 1'b1;
    @(negedge clk);
    b1.send_resp = 1'b0;
    checks++;
    if (b1.resp !== 8'hA5 || b1.cmd_rdy !== 1'b0 || b1.mv_indx !== 5'd0) begin
      fails++; $display("[TB] FAIL single_done: got resp=%h rdy=%b idx=%0d expected a5/0/0", b1.resp, b1.cmd_rdy, b1.mv_indx);
    end
  endtask

  task automatic test_illegal();
    store24[0] = 8'h03;
    b24.cmd_UART = 16'hA1B2;
    start_tour24();
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (b24.cmd_rdy !== 1'b0) begin fails++; $display("[TB] FAIL illegal_rdy: got %b expected 0 (cycle %0d)", b24.cmd_rdy, n); end
      @(negedge clk);
    end
    checks++;
    if (b24.resp !== 8'hEE) begin fails++; $display("[TB] FAIL illegal_resp: got %h expected ee", b24.resp); end
    checks++;
    if (b24.cmd !== 16'hA1B2 || b24.mv_indx !== 5'd0) begin
      fails++; $display("[TB] FAIL illegal_idle: got cmd=%h idx=%0d expected a1b2/0", b24.cmd, b24.mv_indx);
    end
  endtask

  task automatic test_corners();
    store24[0] = 8'h40;
    exp_q.delete();
    push_move(8'h40);
    start_tour24();
    checks++;
    if (b24.resp !== 8'h5A) begin fails++; $display("[TB] FAIL corner_err_clear: got %h expected 5a", b24.resp); end
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (b24.cmd_rdy !== 1'b1 || b24.cmd !== exp) begin
      fails++; $display("[TB] FAIL corner_leg1: got rdy=%b cmd=%h expected 1/%h", b24.cmd_rdy, b24.cmd, exp);
    end
    b24.clr_cmd_rdy = 1'b1;
    b24.send_resp = 1'b1;
    @(negedge clk);
    b24.clr_cmd_rdy = 1'b0;
    b24.send_resp = 1'b0;
    checks++;
    if (b24.cmd_rdy !== 1'b0) begin fails++; $display("[TB] FAIL corner_coincident: got cmd_rdy %b expected 0", b24.cmd_rdy); end
    b24.tour_go = 1'b1;
    @(negedge clk);
    b24.tour_go = 1'b0;
    @(negedge clk);
    checks++;
    if (b24.cmd_rdy !== 1'b0 || b24.mv_indx !== 5'd0) begin
      fails++; $display("[TB] FAIL corner_go_in_wait: got rdy=%b idx=%0d expected 0/0", b24.cmd_rdy, b24.mv_indx);
    end
    b24.send_resp = 1'b1;
    @(negedge clk);
    b24.send_resp = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (b24.cmd_rdy !== 1'b1 || b24.cmd !== exp) begin
      fails++; $display("[TB] FAIL corner_leg2: got rdy=%b cmd=%h expected 1/%h", b24.cmd_rdy, b24.cmd, exp);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_tour();
    bit ok;
    exp_q.delete();
    for (int i = 0; i < 24; i++) begin
      store24[i] = 8'h01 << $urandom_range(7, 0);
      push_move(store24[i]);
    end
    start_tour24();
    for (int c = 0; c < 48; c++) begin
      wait_rdy24(ok);
      checks++;
      if (!ok) begin fails++; $display("[TB] FAIL tour_timeout: got no cmd_rdy expected cmd %0d", c); break; end
      exp = exp_q.pop_front();
      checks++;
      if (b24.cmd !== exp) begin fails++; $display("[TB] FAIL tour_cmd: got %h expected %h (cmd %0d)", b24.cmd, exp, c); end
      checks++;
      if (b24.mv_indx !== 5'(c / 2)) begin fails++; $display("[TB] FAIL tour_indx: got %0d expected %0d", b24.mv_indx, c / 2); end
      b24.clr_cmd_rdy = 1'b1;
      @(negedge clk);
      b24.clr_cmd_rdy = 1'b0;
      checks++;
      if (b24.cmd_rdy !== 1'b0) begin fails++; $display("[TB] FAIL tour_drop: got cmd_rdy %b expected 0 (cmd %0d)", b24.cmd_rdy, c); end
      b24.send_resp = 1'b1;
      @(negedge clk);
      b24.send_resp = 1'b0;
    end
    checks++;
    if (b24.resp !== 8'hA5 || b24.mv_indx !== 5'd23) begin
      fails++; $display("[TB] FAIL tour_end: got resp=%h idx=%0d expected a5/23", b24.resp, b24.mv_indx);
    end
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("[TB] FAIL tour_leftover: got %0d queued expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_tour();
    bit ok;
    exp_q.delete();
    for (int i = 0; i < 24; i++) begin
      store24[i] = 8'h01 << $urandom_range(7, 0);
      if (i < 6) push_move(store24[i]);
    end
    start_tour24();
    for (int c = 0; c < 12; c++) begin
      wait_rdy24(ok);
      checks++;
      if (!ok) begin fails++; $display("[TB] FAIL midrst_timeout: got no cmd_rdy expected cmd %0d", c); break; end
      exp = exp_q.pop_front();
      checks++;
      if (b24.cmd !== exp) begin fails++; $display("[TB] FAIL midrst_cmd: got %h expected %h (cmd %0d)", b24.cmd, exp, c); end
      b24.clr_cmd_rdy = 1'b1;
      @(negedge clk);
      b24.clr_cmd_rdy = 1'b0;
      if (c < 11) begin
        b24.send_resp = 1'b1;
        @(negedge clk);
        b24.send_resp = 1'b0;
      end
    end
    checks++;
    if (b24.mv_indx !== 5'd5 || b24.cmd_rdy !== 1'b0) begin
      fails++; $display("[TB] FAIL midrst_wait2: got idx=%0d rdy=%b expected 5/0", b24.mv_indx, b24.cmd_rdy);
    end
    rst = 1'b1;
    b24.cmd_UART = 16'h1234;
    b24.cmd_rdy_UART = 1'b1;
    #1;
    checks++;
    if (b24.cmd_rdy !== 1'b1 || b24.cmd !== 16'h1234 || b24.resp !== 8'hA5) begin
      fails++; $display("[TB] FAIL midrst_during: got rdy=%b cmd=%h resp=%h expected 1/1234/a5", b24.cmd_rdy, b24.cmd, b24.resp);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (b24.mv_indx !== 5'd0 || b24.resp !== 8'hA5 || b24.cmd_rdy !== 1'b1) begin
      fails++; $display("[TB] FAIL midrst_after: got idx=%0d resp=%h rdy=%b expected 0/a5/1", b24.mv_indx, b24.resp, b24.cmd_rdy);
    end
    b24.cmd_rdy_UART = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checks++;
      if (b24.cmd_rdy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_quiet: got cmd_rdy %b expected 0", b24.cmd_rdy); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      store24[i] = 8'h01;
      store1[i] = 8'h01;
    end
    b24.tour_go = 1'b0; b24.cmd_UART = 16'h0; b24.cmd_rdy_UART = 1'b0;
    b24.clr_cmd_rdy = 1'b0; b24.send_resp = 1'b0;
    b1.tour_go = 1'b0; b1.cmd_UART = 16'h0; b1.cmd_rdy_UART = 1'b0;
    b1.clr_cmd_rdy = 1'b0; b1.send_resp = 1'b0;
    test_reset();
    test_passthrough();
    test_single_move();
    test_illegal();
    test_corners();
    test_full_tour();
    test_reset_mid_tour();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
